// File: rtl/seq_booth_mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM encoding and Booth digit codes.
package seq_booth_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] BD_ZERO_P = 3'b000;
    localparam logic [2:0] BD_POS1_A = 3'b001;
    localparam logic [2:0] BD_POS1_B = 3'b010;
    localparam logic [2:0] BD_POS2   = 3'b011;
    localparam logic [2:0] BD_NEG2   = 3'b100;
    localparam logic [2:0] BD_NEG1_A = 3'b101;
    localparam logic [2:0] BD_NEG1_B = 3'b110;
    localparam logic [2:0] BD_ZERO_N = 3'b111;

endpackage

// File: rtl/seq_booth_mul_booth_gen.sv
// Radix-4 Booth partial-product generator: negative digits come out as the one's complement
// plus a separate correction bit, so the full two's-complement value is pp + neg_o.
module ModRadix4BoothGen
    import seq_booth_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       digit_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH:0]   pp_o,
    output logic             neg_o
);

    logic [WIDTH:0] mcand_x1;
    logic [WIDTH:0] mcand_x2;

    assign mcand_x1 = {mcand_i[WIDTH-1], mcand_i};
    assign mcand_x2 = {mcand_i, 1'b0};

    always_comb begin
        pp_o  = '0;
        neg_o = 1'b0;
        case (digit_i)
            BD_ZERO_P: begin pp_o = '0;         neg_o = 1'b0; end
            BD_POS1_A: begin pp_o = mcand_x1;   neg_o = 1'b0; end
            BD_POS1_B: begin pp_o = mcand_x1;   neg_o = 1'b0; end
            BD_POS2:   begin pp_o = mcand_x2;   neg_o = 1'b0; end
            BD_NEG2:   begin pp_o = ~mcand_x2;  neg_o = 1'b1; end
            BD_NEG1_A: begin pp_o = ~mcand_x1;  neg_o = 1'b1; end
            BD_NEG1_B: begin pp_o = ~mcand_x1;  neg_o = 1'b1; end
            BD_ZERO_N: begin pp_o = '0;         neg_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential radix-4 Booth multiplier, one digit per cycle; SEQ_BOOTH_SKIP_ZERO_EN enables early exit.
// state | meaning:  IDLE | waiting for operands,  CALC | one Booth digit per edge,  DONE | product held
module seq_booth_mul
    import seq_booth_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NDIG  = WIDTH / 2;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int PW    = 2 * WIDTH;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH:0]     mreg_q;
    logic [WIDTH:0]     mreg_d;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [WIDTH:0]     pp;
    logic               pp_neg;
    logic [PW-1:0]      term;
    logic               last_digit;

    ModRadix4BoothGen #(.WIDTH(WIDTH)) u_booth_gen (
        .digit_i (mreg_q[2:0]),
        .mcand_i (a_q),
        .pp_o    (pp),
        .neg_o   (pp_neg)
    );

`ifdef SEQ_BOOTH_SKIP_ZERO_EN
    logic rest_trivial;
`endif

    always_comb begin
        term   = {{(PW-WIDTH-1){pp[WIDTH]}}, pp} + {{(PW-1){1'b0}}, pp_neg};
        acc_d  = acc_q + (term << {cnt_q, 1'b0});
        // Arithmetic shift keeps the vacated digits equal to the sign, so they encode zero.
        mreg_d = {mreg_q[WIDTH], mreg_q[WIDTH], mreg_q[WIDTH:2]};
`ifdef SEQ_BOOTH_SKIP_ZERO_EN
        rest_trivial = (mreg_d == '0) || (mreg_d == '1);
        last_digit   = (cnt_q == CNT_W'(NDIG - 1)) || rest_trivial;
`else
        last_digit   = (cnt_q == CNT_W'(NDIG - 1));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            mreg_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        mreg_q     <= {b, 1'b0};
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= ST_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CALC: begin
                    acc_q  <= acc_d;
                    mreg_q <= mreg_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_digit) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = acc_q;

endmodule
